ncc_array: RTL

Parametrised normalised-cross-correlation compute array: holds a ROWS×COLS signed descriptor and slides a streamed window past it, producing one per-row correlation vector plus a full-patch sum per accepted window column. Successor to the fixed 16×16 PE grid, with these additions:
- configurable geometry and pixel/accumulator widths;
- valid/ready descriptor and window streams;
- a reload path.

It sits between the descriptor buffer and the match-score/peak-search stage in the vision pipeline.

---
 rtl/ncc_array.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ncc_array.sv
// ncc_array: normalised-cross-correlation compute array.
//
// Holds a ROWS x COLS signed descriptor, loaded PPW pixels per word, and
// slides a streamed window (one pixel per row per column) past it. For every
// accepted window column, once the window is full, it produces a per-row
// correlation vector and the sum of all rows.
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   desc_valid/desc_ready/desc_data
//                                 descriptor word stream, pixel 0 in MSBs
//   desc_done                     one-cycle pulse after the last descriptor word
//   load_req                      pulse in RUN: abandon and reload descriptor
//   win_valid/win_ready/win_data  window column stream, row 0 in MSBs
//   acc_valid                     one-cycle strobe for acc_data/corr_sum
//   acc_data                      per-row correlation, row 0 in MSBs
//   corr_sum                      signed sum of all acc_data rows
//
// Build option: define NCC_SATURATE_EN to clamp each row sum to the ACC_W
// signed range; otherwise row sums wrap modulo 2^ACC_W.
module ncc_array #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int PIX_W = 8,
  parameter int PPW   = 4,
  parameter int ACC_W = 24
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             desc_valid,
  output logic                             desc_ready,
  input  logic [PPW*PIX_W-1:0]             desc_data,
  output logic                             desc_done,
  input  logic                             load_req,
  input  logic                             win_valid,
  output logic                             win_ready,
  input  logic [ROWS*PIX_W-1:0]            win_data,
  output logic                             acc_valid,
  output logic [ROWS*ACC_W-1:0]            acc_data,
  output logic [ACC_W+$clog2(ROWS)-1:0]    corr_sum
);

  localparam int WPR    = COLS / PPW;
  localparam int NWORDS = ROWS * WPR;
  localparam int WCNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int FILL_W = $clog2(COLS + 1);
  localparam int SUM_W  = 2 * PIX_W + $clog2(COLS);
  localparam int EXT_W  = (SUM_W > ACC_W) ? SUM_W : ACC_W;
  localparam int CS_W   = ACC_W + $clog2(ROWS);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [WCNT_W-1:0] word_cnt;
  logic [FILL_W-1:0] fill_cnt;

  logic signed [PIX_W-1:0] desc_q  [ROWS][COLS];
  logic signed [PIX_W-1:0] win_q   [ROWS][COLS];
  logic signed [PIX_W-1:0] win_nxt [ROWS][COLS];
  logic signed [SUM_W-1:0] row_sum [ROWS];
  logic signed [ACC_W-1:0] row_red [ROWS];
  logic signed [CS_W-1:0]  sum_red;

  logic desc_fire, win_fire, out_fire, last_word;

  assign desc_ready = (state == ST_LOAD);
  assign win_ready  = (state == ST_RUN) && !load_req;
  assign desc_fire  = desc_ready && desc_valid;
  assign win_fire   = win_ready && win_valid;
  assign last_word  = (word_cnt == WCNT_W'(NWORDS - 1));
  // The fill counter still holds the pre-acceptance count here, so the
  // COLS-th column is the one arriving while it reads COLS-1.
  assign out_fire   = win_fire && (fill_cnt >= FILL_W'(COLS - 1));

  // Reduce a full-precision row sum to ACC_W bits.
  function automatic logic signed [ACC_W-1:0] reduce_row(input logic signed [SUM_W-1:0] s);
`ifdef NCC_SATURATE_EN
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] hi;
    logic signed [EXT_W-1:0] lo;
    ext = EXT_W'(s);
    hi  = {{(EXT_W - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
    lo  = ~hi;
    if (ext > hi)      return ACC_W'(hi);
    else if (ext < lo) return ACC_W'(lo);
    else               return ACC_W'(ext);
`else
    return ACC_W'(s);
`endif
  endfunction

  // Correlation is taken against the window as it will look after the
  // incoming column has been shifted in, so the result registers on the
  // same edge that accepts the column.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here the
    // accumulators start at zero) so no latch can be inferred.
    sum_red = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS - 1; c++) win_nxt[r][c] = win_q[r][c + 1];
      win_nxt[r][COLS - 1] = win_data[(ROWS - 1 - r) * PIX_W +: PIX_W];
      row_sum[r] = '0;
      for (int c = 0; c < COLS; c++)
        row_sum[r] = row_sum[r] + SUM_W'(desc_q[r][c]) * SUM_W'(win_nxt[r][c]);
      row_red[r] = reduce_row(row_sum[r]);
      sum_red    = sum_red + CS_W'(row_red[r]);
    end
  end

  // Control: LOAD/RUN sequencing, word and fill counters, strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      word_cnt  <= '0;
      fill_cnt  <= '0;
      desc_done <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      desc_done <= 1'b0;
      acc_valid <= out_fire;
      case (state)
        ST_LOAD: begin
          if (desc_fire) begin
            if (last_word) begin
              state     <= ST_RUN;
              word_cnt  <= '0;
              desc_done <= 1'b1;
            end else begin
              word_cnt <= word_cnt + WCNT_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (load_req) begin
            state    <= ST_LOAD;
            word_cnt <= '0;
            fill_cnt <= '0;
          end else if (win_fire && (fill_cnt != FILL_W'(COLS))) begin
            fill_cnt <= fill_cnt + FILL_W'(1);
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // Datapath: descriptor and window storage plus output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: descriptor and window arrays are cleared on reset because
      // downstream observes zeroed state; storage that is always written
      // before it is read would normally be left without reset.
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          desc_q[r][c] <= '0;
          win_q[r][c]  <= '0;
        end
      end
      acc_data <= '0;
      corr_sum <= '0;
    end else begin
      if (desc_fire) begin
        for (int w = 0; w < NWORDS; w++) begin
          if (word_cnt == WCNT_W'(w)) begin
            for (int p = 0; p < PPW; p++)
              desc_q[w / WPR][(w % WPR) * PPW + p] <= desc_data[(PPW - 1 - p) * PIX_W +: PIX_W];
          end
        end
      end
      if (win_fire) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) win_q[r][c] <= win_nxt[r][c];
        end
      end
      // Outputs only move on a strobe so they hold between results.
      if (out_fire) begin
        for (int r = 0; r < ROWS; r++)
          acc_data[(ROWS - 1 - r) * ACC_W +: ACC_W] <= row_red[r];
        corr_sum <= sum_red;
      end
    end
  end

endmodule
